// File: rtl/lock_range_sweeper.sv
// lock_range_sweeper
// Sequencer for ADPLL lock-range characterisation. It steps the PhaseAccum k value
// across a programmed range and waits a settle time at each point. It then
// qualifies the RingADPLL phase error over a measurement window and records the
// lowest and highest k at which the loop locked.
//
// Build option: ADPLL_STEP_RESET_EN
//   defined   - the ADPLL is held in reset for RST_CYCLES at the start of every
//               point, so each point is a fresh acquisition (pull-in range).
//   undefined - no per-point reset, adpll_rst_o is tied low and the loop tracks
//               across steps (hold-in range).
module lock_range_sweeper #(
  parameter int ACCUM_WIDTH   = 12,
  parameter int ERR_WIDTH     = 8,
  parameter int SETTLE_CYCLES = 65536,
  parameter int MEAS_CYCLES   = 4096,
  parameter int LOCK_THRESH   = 2,
  parameter int RST_CYCLES    = 16
) (
  input  logic                        fpga_clk_i,
  input  logic                        rst_n_i,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic [ACCUM_WIDTH-1:0]      k_start_i,
  input  logic [ACCUM_WIDTH-1:0]      k_end_i,
  input  logic [ACCUM_WIDTH-1:0]      k_step_i,
  input  logic signed [ERR_WIDTH-1:0] error_i,
  output logic [ACCUM_WIDTH-1:0]      k_val_o,
  output logic                        adpll_rst_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        locked_o,
  output logic                        lock_found_o,
  output logic [ACCUM_WIDTH-1:0]      lock_lo_o,
  output logic [ACCUM_WIDTH-1:0]      lock_hi_o
);

  // One shared phase counter serves PRST, SETTLE and MEAS, so it is sized for
  // the longest of the three phases.
  localparam int MaxSetMeas = (SETTLE_CYCLES > MEAS_CYCLES) ? SETTLE_CYCLES : MEAS_CYCLES;
  localparam int MaxCycles  = (MaxSetMeas > RST_CYCLES) ? MaxSetMeas : RST_CYCLES;
  localparam int CntW       = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] MeasLast   = CntW'(MEAS_CYCLES - 1);
`ifdef ADPLL_STEP_RESET_EN
  localparam logic [CntW-1:0] RstLast    = CntW'(RST_CYCLES - 1);
`endif

  // Most negative error code and the largest positive magnitude it saturates to.
  localparam logic [ERR_WIDTH-1:0] ErrMin    = {1'b1, {(ERR_WIDTH-1){1'b0}}};
  localparam logic [ERR_WIDTH-1:0] ErrMaxPos = {1'b0, {(ERR_WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {
    IDLE,
    PRST,
    SETTLE,
    MEAS,
    STEP,
    DONE
  } state_t;

  state_t                 state_q;
  logic [ACCUM_WIDTH-1:0] kVal_q;
  logic [ACCUM_WIDTH-1:0] kEnd_q;
  logic [ACCUM_WIDTH-1:0] kStep_q;
  logic [CntW-1:0]        cnt_q;
  logic                   winOk_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   locked_q;
  logic                   lockFound_q;
  logic [ACCUM_WIDTH-1:0] lockLo_q;
  logic [ACCUM_WIDTH-1:0] lockHi_q;
`ifdef ADPLL_STEP_RESET_EN
  logic                   adpllRst_q;
`endif

  logic [ERR_WIDTH-1:0]   errMag;
  logic                   sampleOk;
  logic [ACCUM_WIDTH:0]   kNext_d;
  logic                   stepPastEnd;
  logic                   windowLocked;

  // Magnitude of the signed phase error; the most negative code has no positive
  // twin, so it saturates to the largest positive value instead of wrapping.
  always_comb begin
    errMag = error_i;
    if (error_i == ErrMin) begin
      errMag = ErrMaxPos;
    end else if (error_i[ERR_WIDTH-1]) begin
      errMag = -error_i;
    end
  end

  // Per-sample lock test and the extra-bit next-k sum used to catch both the
  // range end and a carry out of the k register.
  always_comb begin
    sampleOk     = (errMag <= ERR_WIDTH'(LOCK_THRESH));
    windowLocked = winOk_q && sampleOk;
    kNext_d      = {1'b0, kVal_q} + {1'b0, kStep_q};
    stepPastEnd  = kNext_d[ACCUM_WIDTH] || (kNext_d[ACCUM_WIDTH-1:0] > kEnd_q);
  end

  // Sweep sequencer: single registered FSM owning k, the phase counter and all results.
  always_ff @(posedge fpga_clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      kVal_q      <= '0;
      kEnd_q      <= '0;
      kStep_q     <= '0;
      cnt_q       <= '0;
      winOk_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      locked_q    <= 1'b0;
      lockFound_q <= 1'b0;
      lockLo_q    <= '0;
      lockHi_q    <= '0;
`ifdef ADPLL_STEP_RESET_EN
      adpllRst_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (abort_i && (state_q == PRST || state_q == SETTLE ||
                      state_q == MEAS || state_q == STEP)) begin
        // Abort drops any partial window; locked_o keeps the last full result.
        state_q <= DONE;
        done_q  <= 1'b1;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
`ifdef ADPLL_STEP_RESET_EN
        adpllRst_q <= 1'b0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i && !abort_i) begin
              kVal_q      <= k_start_i;
              kEnd_q      <= k_end_i;
              kStep_q     <= (k_step_i == '0) ? ACCUM_WIDTH'(1) : k_step_i;
              lockFound_q <= 1'b0;
              lockLo_q    <= '0;
              lockHi_q    <= '0;
              locked_q    <= 1'b0;
              busy_q      <= 1'b1;
              cnt_q       <= '0;
`ifdef ADPLL_STEP_RESET_EN
              adpllRst_q  <= 1'b1;
              state_q     <= PRST;
`else
              state_q     <= SETTLE;
`endif
            end
          end

`ifdef ADPLL_STEP_RESET_EN
          PRST: begin
            if (cnt_q == RstLast) begin
              cnt_q      <= '0;
              adpllRst_q <= 1'b0;
              state_q    <= SETTLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
`else
          PRST: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
`endif

          SETTLE: begin
            if (cnt_q == SettleLast) begin
              cnt_q   <= '0;
              winOk_q <= 1'b1;
              state_q <= MEAS;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end

          MEAS: begin
            if (!sampleOk) begin
              winOk_q <= 1'b0;
            end
            if (cnt_q == MeasLast) begin
              cnt_q    <= '0;
              locked_q <= windowLocked;
              state_q  <= STEP;
              if (windowLocked) begin
                lockFound_q <= 1'b1;
                lockHi_q    <= kVal_q;
                if (!lockFound_q) begin
                  lockLo_q <= kVal_q;
                end
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end

          STEP: begin
            if (stepPastEnd) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              kVal_q <= kNext_d[ACCUM_WIDTH-1:0];
              cnt_q  <= '0;
`ifdef ADPLL_STEP_RESET_EN
              adpllRst_q <= 1'b1;
              state_q    <= PRST;
`else
              state_q    <= SETTLE;
`endif
            end
          end

          DONE: begin
            state_q <= IDLE;
          end

          default: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign k_val_o      = kVal_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign locked_o     = locked_q;
  assign lock_found_o = lockFound_q;
  assign lock_lo_o    = lockLo_q;
  assign lock_hi_o    = lockHi_q;
`ifdef ADPLL_STEP_RESET_EN
  assign adpll_rst_o  = adpllRst_q;
`else
  assign adpll_rst_o  = 1'b0;
`endif

endmodule
